// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: control codes, aluop classes,
// func7 patterns and the sequencing FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SLL    = 4'b0011;
  localparam logic [3:0] ALU_SRL    = 4'b0100;
  localparam logic [3:0] ALU_SRA    = 4'b0101;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_BNE    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1010;
  localparam logic [3:0] ALU_XOR    = 4'b1100;
  localparam logic [3:0] ALU_MULDIV = 4'b1111;

  localparam logic [1:0] AOP_ITYPE  = 2'b00;
  localparam logic [1:0] AOP_BRANCH = 2'b01;
  localparam logic [1:0] AOP_RTYPE  = 2'b10;
  localparam logic [1:0] AOP_ADD    = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [6:0] F7_JAL    = 7'b1101111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  // Integer-op decode shared by I-type and base R-type encodings.
  function automatic logic [3:0] base_ctrl(input logic [2:0] func3, input logic [6:0] func7);
    case (func3)
      3'b000:  base_ctrl = ALU_ADD;
      3'b001:  base_ctrl = ALU_SLL;
      3'b010:  base_ctrl = ALU_SLT;
      3'b011:  base_ctrl = ALU_SLTU;
      3'b100:  base_ctrl = ALU_XOR;
      3'b101:  base_ctrl = (func7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      3'b110:  base_ctrl = ALU_OR;
      default: base_ctrl = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative RV-M multiply/divide: shift-add / restoring division on magnitudes,
// one bit per cycle, with sign fix-up at the output. Built only with ALU_MULDIV_EN.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;

  logic            busy, neg_q, neg_r, dbz;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] acc, acc_src, acc_step, prod;
  logic [XLEN-1:0] mag_m, m_src, a_orig, mag_a, mag_b, quo, rem;
  logic [2:0]      fn;
  logic            a_sgn, b_sgn, sa, sb, is_div;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    a_sgn = func3[2] ? !func3[0] : (func3[1:0] != 2'b11);
    b_sgn = func3[2] ? !func3[0] : !func3[1];
    sa    = a_sgn & op_a[XLEN-1];
    sb    = b_sgn & op_b[XLEN-1];
    mag_a = sa ? -op_a : op_a;
    mag_b = sb ? -op_b : op_b;
  end

  // The first iteration runs on the start edge so the result lands XLEN cycles later.
  assign is_div  = start ? func3[2] : fn[2];
  assign m_src   = start ? (func3[2] ? mag_b : mag_a) : mag_m;
  assign acc_src = start ? {{XLEN{1'b0}}, (func3[2] ? mag_a : mag_b)} : acc;

  assign mul_sum   = {1'b0, acc_src[2*XLEN-1:XLEN]} + (acc_src[0] ? {1'b0, m_src} : '0);
  assign div_shift = acc_src[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, m_src};

  always_comb begin
    if (!is_div)
      acc_step = {mul_sum, acc_src[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_step = {div_diff[XLEN-1:0], acc_src[XLEN-2:0], 1'b1};
    else
      acc_step = {div_shift[XLEN-1:0], acc_src[XLEN-2:0], 1'b0};
  end

  assign done = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mag_m  <= '0;
      a_orig <= '0;
      fn     <= 3'b000;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(XLEN - 1);
      acc    <= acc_step;
      mag_m  <= m_src;
      a_orig <= op_a;
      fn     <= func3;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      dbz    <= (op_b == '0);
    end else if (busy) begin
      if (cnt != '0) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign prod = neg_q ? -acc : acc;
  assign quo  = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

  always_comb begin
    if (!fn[2])
      result = (fn[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (!fn[1])
      result = dbz ? '1 : (neg_q ? -quo : quo);
    else
      result = dbz ? a_orig : (neg_r ? -rem : rem);
  end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with aluop/func7/func3 decode and valid/ready result register.
// Define ALU_MULDIV_EN to build the iterative RV-M multiply/divide path.
//
// state   | meaning
// IDLE    | empty, accepting operations
// MUL     | iterative multiply in progress
// DIV     | iterative divide/remainder in progress
// DONE    | result held until out_ready
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  import alu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  state_t          state;
  logic [3:0]      ctrl;
  logic            dec_bad, accept, zero_nxt;
  logic [XLEN-1:0] alu_res, res_nxt;
  logic [SHW-1:0]  shamt;

  always_comb begin
    ctrl    = ALU_ADD;
    dec_bad = 1'b0;
    case (aluop)
      AOP_ITYPE: ctrl = base_ctrl(func3, func7);
      AOP_BRANCH: begin
        if (func7 == F7_JAL) ctrl = ALU_ADD;
        else begin
          case (func3)
            3'b000:         ctrl = ALU_SUB;
            3'b001:         ctrl = ALU_BNE;
            3'b100, 3'b101: ctrl = ALU_SLT;
            3'b110, 3'b111: ctrl = ALU_SLTU;
            default:        dec_bad = 1'b1;
          endcase
        end
      end
      AOP_RTYPE: begin
        if (func7 == F7_BASE) ctrl = base_ctrl(func3, func7);
        else if (func7 == F7_ALT && func3 == 3'b000) ctrl = ALU_SUB;
        else if (func7 == F7_ALT && func3 == 3'b101) ctrl = ALU_SRA;
`ifdef ALU_MULDIV_EN
        else if (func7 == F7_MULDIV) ctrl = ALU_MULDIV;
`endif
        else dec_bad = 1'b1;
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    case (ctrl)
      ALU_AND:          alu_res = op_a & op_b;
      ALU_OR:           alu_res = op_a | op_b;
      ALU_XOR:          alu_res = op_a ^ op_b;
      ALU_ADD:          alu_res = op_a + op_b;
      ALU_SUB, ALU_BNE: alu_res = op_a - op_b;
      ALU_SLL:          alu_res = op_a << shamt;
      ALU_SRL:          alu_res = op_a >> shamt;
      ALU_SRA:          alu_res = XLEN'($signed(op_a) >>> shamt);
      ALU_SLT:          alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:         alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default:          alu_res = '0;
    endcase
  end

  // BNE reports "not equal" on zero so the branch unit can treat it like BEQ.
  assign res_nxt  = dec_bad ? '0 : alu_res;
  assign zero_nxt = (ctrl == ALU_BNE && !dec_bad) ? (res_nxt != '0) : (res_nxt == '0);

  assign in_ready = !flush && (state == ST_IDLE || (state == ST_DONE && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  logic            md_start, md_done;
  logic [XLEN-1:0] md_result;

  assign md_start = accept && !dec_bad && (ctrl == ALU_MULDIV);

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .flush  (flush),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .done   (md_done),
    .result (md_result)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
`ifdef ALU_MULDIV_EN
          if (md_start) begin
            state     <= func3[2] ? ST_DIV : ST_MUL;
            out_valid <= 1'b0;
          end else
`endif
          if (accept) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= res_nxt;
            zero      <= zero_nxt;
            illegal   <= dec_bad;
          end else if (state == ST_DONE && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MULDIV_EN
        ST_MUL, ST_DIV: begin
          if (md_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= md_result;
            zero      <= (md_result == '0);
            illegal   <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [1:0]      aluop = 2'b00;
  logic [6:0]      func7 = 7'h00;
  logic [2:0]      func3 = 3'b000;
  logic [XLEN-1:0] op_a = '0, op_b = '0;
  logic            in_ready, out_valid, zero, illegal;
  logic [XLEN-1:0] result;

  int n_cmp = 0, n_bad = 0;

  localparam int K_ADD = 0, K_SUB = 1, K_SLL = 2, K_SLT = 3, K_SLTU = 4, K_XOR = 5,
                 K_SRL = 6, K_SRA = 7, K_OR = 8, K_AND = 9, K_BNE = 10, K_MD = 11;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int base_kind(input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0: return K_ADD;
      3'd1: return K_SLL;
      3'd2: return K_SLT;
      3'd3: return K_SLTU;
      3'd4: return K_XOR;
      3'd5: return (f7 == 7'h20) ? K_SRA : K_SRL;
      3'd6: return K_OR;
      default: return K_AND;
    endcase
  endfunction

  function automatic void ref_op(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic z, output logic ill, output logic md);
    int k;
    longint sp;
    logic [63:0] up;
    logic signed [31:0] sa, sbv;
    logic [4:0] sh;
    sa = a; sbv = b; sh = b[4:0];
    ill = 1'b0; md = 1'b0; k = K_ADD; r = '0;
    case (aop)
      2'b00: k = base_kind(f3, f7);
      2'b01: begin
        if (f7 == 7'h6F) k = K_ADD;
        else if (f3 == 3'd0) k = K_SUB;
        else if (f3 == 3'd1) k = K_BNE;
        else if (f3 == 3'd4 || f3 == 3'd5) k = K_SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) k = K_SLTU;
        else ill = 1'b1;
      end
      2'b10: begin
        if (f7 == 7'h00) k = base_kind(f3, f7);
        else if (f7 == 7'h20 && f3 == 3'd0) k = K_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) k = K_SRA;
        else if (f7 == 7'h01) begin md = 1'b1; k = K_MD; end
        else ill = 1'b1;
      end
      default: k = K_ADD;
    endcase
`ifndef ALU_MULDIV_EN
    if (md) begin md = 1'b0; ill = 1'b1; end
`endif
    case (k)
      K_ADD:  r = a + b;
      K_SUB, K_BNE: r = a - b;
      K_SLL:  r = a << sh;
      K_SRL:  r = a >> sh;
      K_SRA:  r = sa >>> sh;
      K_SLT:  r = (sa < sbv) ? 32'd1 : 32'd0;
      K_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      K_XOR:  r = a ^ b;
      K_OR:   r = a | b;
      K_AND:  r = a & b;
      default: begin
        case (f3)
          3'd0: begin sp = longint'(sa) * longint'(sbv); r = sp[31:0]; end
          3'd1: begin sp = longint'(sa) * longint'(sbv); r = sp[63:32]; end
          3'd2: begin sp = longint'(sa) * longint'({32'h0, b}); r = sp[63:32]; end
          3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
          3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : sa / sbv;
          3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
          3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : sa % sbv;
          default: r = (b == 0) ? a : a % b;
        endcase
      end
    endcase
    if (ill) r = '0;
    z = (k == K_BNE && !ill) ? (r != 0) : (r == 0);
  endfunction

  // Issues one op with out_ready high and checks latency, result, zero, illegal.
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic ez, ei, emd, busy_ok;
    int guard, lat;
    ref_op(aop, f7, f3, a, b, er, ez, ei, emd);
    out_ready = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) chk({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; aluop = aop; func7 = f7; func3 = f3; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk); lat++;
      if (!out_valid && in_ready) busy_ok = 1'b0;
    end while (!out_valid && lat < 100);
    chk({tag, "_lat"}, 64'(lat), emd ? 64'(XLEN + 1) : 64'd1);
    if (emd) chk({tag, "_busy_inready"}, 64'(busy_ok), 64'd1);
    chk({tag, "_res"}, 64'(result), 64'(er));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
    chk({tag, "_ill"}, 64'(illegal), 64'(ei));
  endtask

  logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [6:0]  f7set   [4] = '{7'h00, 7'h20, 7'h01, 7'h6F};

  initial begin
    logic [31:0] ra, rb, held, exp_b2b [4];
    logic [6:0]  rf7;
    logic        stayed_low;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("sra", 2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4);
    chk("sra_const", 64'(result), 64'hF800_0000);
    run_op("bne_eq", 2'b01, 7'h00, 3'd1, 32'd5, 32'd5);
    chk("bne_zero_const", 64'(zero), 64'd0);
    run_op("jal", 2'b01, 7'h6F, 3'd1, 32'd100, 32'd4);
    run_op("bad_rtype", 2'b10, 7'h10, 3'd0, 32'd1, 32'd2);
    run_op("mulh", 2'b10, 7'h01, 3'd1, 32'hFFFF_FFFF, 32'd7);
    run_op("div_ovf", 2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("remu_dz", 2'b10, 7'h01, 3'd7, 32'd9, 32'd0);
    run_op("div_dz", 2'b10, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd0);
`ifdef ALU_MULDIV_EN
    run_op("mulh_c", 2'b10, 7'h01, 3'd1, 32'hFFFF_FFFF, 32'd7);
    chk("mulh_const", 64'(result), 64'hFFFF_FFFF);
    run_op("div_c", 2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", 64'(result), 64'h8000_0000);
    run_op("remu_c", 2'b10, 7'h01, 3'd7, 32'd9, 32'd0);
    chk("remu_dz_const", 64'(result), 64'd9);
`else
    run_op("md_off", 2'b10, 7'h01, 3'd0, 32'd3, 32'd4);
    chk("md_off_ill_const", 64'(illegal), 64'd1);
`endif

    // Hold a result with out_ready low, then accept a new op in the releasing cycle.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; aluop = 2'b11; op_a = 32'd10; op_b = 32'd20;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stall_first", 64'(result), 64'd30);
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold_res", 64'(result), 64'(held));
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
      chk("stall_inready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; op_a = 32'd7; op_b = 32'd8;
    #1 chk("release_inready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("release_res", 64'(result), 64'd15);
    chk("release_valid", 64'(out_valid), 64'd1);

    // Back-to-back single-cycle ops at full throughput.
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_b2b[i] = 32'(i * 1000 + 3) + 32'(i + 77);
    in_valid = 1'b1; aluop = 2'b11; op_a = 32'd3; op_b = 32'd77;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin op_a = 32'((i + 1) * 1000 + 3); op_b = 32'(i + 1 + 77); end
      else in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_res", 64'(result), 64'(exp_b2b[i]));
      chk("b2b_inready", 64'(in_ready), 64'd1);
    end

    // Flush a held result while offering a new op: op is dropped, out_valid clears.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; aluop = 2'b11; op_a = 32'd1; op_b = 32'd1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op_a = 32'd100;
    #1 chk("flush_inready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 begin flush = 1'b0; in_valid = 1'b0; end
    stayed_low = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (out_valid) stayed_low = 1'b0; end
    chk("flush_no_valid", 64'(stayed_low), 64'd1);
    run_op("post_flush_add", 2'b11, 7'h00, 3'd0, 32'd2, 32'd3);
    chk("post_flush_const", 64'(result), 64'd5);

`ifdef ALU_MULDIV_EN
    // Flush ten cycles into a divide.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; aluop = 2'b10; func7 = 7'h01; func3 = 3'd4;
    op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    stayed_low = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (out_valid) stayed_low = 1'b0; end
    chk("div_flush_no_valid", 64'(stayed_low), 64'd1);
    run_op("div_flush_add", 2'b11, 7'h00, 3'd0, 32'd2, 32'd3);
    chk("div_flush_add_const", 64'(result), 64'd5);

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    in_valid = 1'b1; aluop = 2'b10; func7 = 7'h01; func3 = 3'd0; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_inready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    stayed_low = 1'b1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) stayed_low = 1'b0; end
    chk("arst_discard", 64'(stayed_low), 64'd1);
`endif

    for (int n = 0; n < 150; n++) begin
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rf7 = ($urandom_range(0, 4) == 4) ? 7'($urandom) : f7set[$urandom_range(0, 3)];
      run_op("rand", 2'($urandom_range(0, 3)), rf7, 3'($urandom_range(0, 7)), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit for the RV32/RV64 pipeline. It decodes `aluop`/`func7`/`func3` into an internal ALU control code, executes the operation and returns a registered result over valid/ready handshakes. Single-cycle integer ops are decoded from the full 7-bit `func7`, which adds SRA/SRAI and SLTU. Optional iterative RV-M multiply/divide makes the EX stage stall-capable. It sits between ID/EX and EX/MEM and replaces the standalone combinational ALU-control decoder.

## Interface
- XLEN, 32, datapath width (32 or 64)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts operation this cycle
- aluop  in  2  00 I-type/load/store, 01 branch, 10 R-type, 11 forced ADD
- func7  in  7  instruction func7
- func3  in  3  instruction func3
- op_a, op_b  in  XLEN  operands
- flush  in  1  abort in-flight operation
- out_valid  out  1  result available
- out_ready  in  1  downstream consumes result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  unsupported encoding; result is 0

## Operation
- Control codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111, BNE 1000, SLTU 1010, XOR 1100, MULDIV 1111.
- aluop 00: func3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if func7=0100000), 110 OR, 111 AND.
- aluop 01: func3 000 SUB, 001 BNE (SUB, zero inverted), 1x0/1x1 SLT/SLTU by func3[1]; func7=1101111 forces ADD (JAL).
- aluop 10: func7 0000000 as aluop 00; 0100000 with func3 000 SUB, 101 SRA; 0000001 MULDIV; any other combination illegal.
- aluop 11: ADD.
- Shift amount is op_b[$clog2(XLEN)-1:0].
- MULDIV func3: 000 MUL (low XLEN), 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Divide by zero: quotient all-ones, remainder = op_a. Signed overflow (most-negative / -1): quotient = op_a, remainder 0.
- FSM: IDLE -> (MULDIV accepted) MUL or DIV -> DONE after XLEN iterations; IDLE -> DONE for single-cycle ops; DONE -> IDLE on out_ready.
- MUL: radix-2 shift-add on magnitudes with sign fix-up. DIV: restoring division on magnitudes, one quotient bit per cycle.

## Timing
- Reset: out_valid 0, result 0, zero 0, illegal 0, state IDLE, iteration counter 0; in_ready 1 after reset release.
- in_ready = state==IDLE, or state==DONE with out_ready (back-to-back single-cycle ops at full throughput).
- Transfer occurs when valid && ready on the same edge.
- Single-cycle op: out_valid asserts the cycle after acceptance.
- MUL/DIV: out_valid asserts XLEN+1 cycles after acceptance; in_ready is 0 meanwhile.
- result, zero and illegal are held stable while out_valid && !out_ready.
- flush: returns to IDLE next cycle and clears out_valid. It has priority over simultaneous in_valid, which is not accepted.
- Asynchronous reset mid-iteration discards the operation immediately.

## Configuration
- ALU_MULDIV_EN defined: MULDIV path and MUL/DIV states are built.
- Not defined: func7=0000001 under aluop 10 reports illegal in one cycle and no iterative logic exists.

## Structure
- alu_pkg holds: control-code localparams, aluop encodings, func7 constants (0000000, 0100000, 0000001, 1101111), FSM state typedef.
- Sub-module alu_muldiv_iter (XLEN-parametrised, start/done handshake) is compiled only under ALU_MULDIV_EN.

## Test plan
- aluop=10, func7=0100000, func3=101, op_a=0x80000000, op_b=4 -> result 0xF8000000 one cycle after accept.
- aluop=01, func3=001, op_a=op_b=5 -> result 0, zero=1 reported as not-taken (BNE inverted zero = 0).
- MUL, XLEN=32, op_a=0xFFFFFFFF (-1), op_b=7, func3=001 -> result 0xFFFFFFFF after 33 cycles; in_ready low throughout.
- DIV op_a=0x80000000, op_b=0xFFFFFFFF -> result 0x80000000. REMU op_b=0 with op_a=9 -> result 9.
- out_ready held low 5 cycles after ADD result -> result stable, in_ready 0. out_ready=1 with a new in_valid -> back-to-back acceptance.
- flush 10 cycles into DIV -> out_valid never asserts; next ADD 2+3 -> 5.
